// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared PS/2 receive types and key constants. The downstream screen/game
//   FSMs import the same constants so make/break decoding stays consistent.
//   Contents: ps2_state_t (receiver FSM states), PS/2 byte constants,
//   ps2_parity_ok() odd-parity check over a data byte plus its parity bit.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_R     = 8'h2D;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [7:0] data_byte, input logic par_bit);
      return ^{data_byte, par_bit};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//   Conditions the raw PS/2 pins for the receiver.
//   ps2_clk : 2-FF synchronizer, then a level filter that only changes after
//             FILTER_LEN consecutive samples disagree with the current level.
//   ps2_data: 2-FF synchronizer only (sampled at filtered clock edges).
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   ps2_clk      raw PS/2 clock pin (async, idle high)
//   ps2_data     raw PS/2 data pin (async, idle high)
//   data_s       synchronized ps2_data
//   fall_strobe  1-cycle pulse on each falling edge of the filtered clock
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall_strobe
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic             clk_meta_q,  clk_meta_d;
   logic             clk_s_q,     clk_s_d;
   logic             data_meta_q, data_meta_d;
   logic             data_s_q,    data_s_d;
   logic             filt_q,      filt_d;
   logic             filt_prev_q, filt_prev_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   always_comb begin
      clk_meta_d  = ps2_clk;
      clk_s_d     = clk_meta_q;
      data_meta_d = ps2_data;
      data_s_d    = data_meta_q;
      filt_d      = filt_q;
      filt_prev_d = filt_q;
      cnt_d       = '0;
      // cnt_q counts consecutive samples that disagree with the filtered level;
      // the sample that would make it FILTER_LEN flips the level instead.
      if (clk_s_q != filt_q) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filt_d = clk_s_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_s_q     <= 1'b1;
         data_meta_q <= 1'b1;
         data_s_q    <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         cnt_q       <= '0;
      end else begin
         clk_meta_q  <= clk_meta_d;
         clk_s_q     <= clk_s_d;
         data_meta_q <= data_meta_d;
         data_s_q    <= data_s_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
         cnt_q       <= cnt_d;
      end
   end

   assign data_s      = data_s_q;
   assign fall_strobe = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//   PS/2 keyboard frame receiver. Frames are start(0), 8 data bits LSB first,
//   odd parity, stop(1). Each accepted byte shifts into a 16-bit keycode
//   {previous byte, latest byte}. Prefix bytes (E0/F0) are not interpreted.
// Ports
//   clk, rst    system clock, synchronous active-high reset
//   ps2_clk     raw PS/2 clock pin
//   ps2_data    raw PS/2 data pin
//   keycode     {previous byte, last accepted byte}, held between updates
//   key_valid   1-cycle pulse in the cycle keycode updates
//   frame_err   1-cycle pulse on parity, stop-bit or inter-bit timeout error
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 at a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, then accept or flag error
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 65_000_000,
   parameter int TIMEOUT_US  = 100,
   parameter int FILTER_LEN  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keycode,
   output logic        key_valid,
   output logic        frame_err
);

   localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

   logic data_s;
   logic strobe;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_line_filter (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .data_s      (data_s),
      .fall_strobe (strobe)
   );

   ps2_state_t  state_q,     state_d;
   logic [2:0]  bit_cnt_q,   bit_cnt_d;
   logic [7:0]  shift_q,     shift_d;
   logic        par_q,       par_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [15:0] keycode_q,   keycode_d;
   logic        key_valid_q, key_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        timeout_hit;

   // The counter reaches TIMEOUT_CYCLES on the same edge the error pulse is
   // registered; a strobe in this cycle takes priority.
   assign timeout_hit = (state_q != IDLE) && !strobe &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      keycode_d   = keycode_q;
      key_valid_d = 1'b0;
      frame_err_d = 1'b0;

      if (state_q == IDLE || strobe) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
         to_cnt_d = to_cnt_q;
      end

      if (strobe) begin
         unique case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_d   = data_s;
               state_d = STOP;
            end
            STOP: begin
               if (data_s && ps2_parity_ok(shift_q, par_q)) begin
                  keycode_d   = {keycode_q[7:0], shift_q};
                  key_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (timeout_hit) begin
         frame_err_d = 1'b1;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         keycode_q   <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         keycode_q   <= keycode_d;
         key_valid_q <= key_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign keycode   = keycode_q;
   assign key_valid = key_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx
//   Directed bench for ps2_keycode_rx. Runs a 2 MHz system clock so a
//   12.5 kHz PS/2 bit period is 160 cycles and the 100 us timeout is 200 cycles.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

   localparam int CLK_HZ     = 2_000_000;
   localparam int TO_US      = 100;
   localparam int FLT_LEN    = 8;
   localparam int TO_CYC     = 200;   // 2 cycles/us * 100 us
   localparam int HALF       = 80;    // half PS/2 bit period in clk cycles
   localparam int QTR        = 40;
   localparam int GLITCH_LEN = FLT_LEN - 1;
   // Raw clock fall -> strobe: 2 sync + 8 filter samples; strobe -> frame_err
   // output register: TO_CYC + 1. Measured in clk edges from the raw fall.
   localparam int TO_LATENCY = TO_CYC + 11;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keycode;
   logic        key_valid;
   logic        frame_err;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          kv_cnt       = 0;
   int          fe_cnt       = 0;
   int          both_cnt     = 0;
   logic [15:0] kc_log[$];
   logic [15:0] exp_kc;

   ps2_keycode_rx #(
      .CLK_FREQ_HZ (CLK_HZ),
      .TIMEOUT_US  (TO_US),
      .FILTER_LEN  (FLT_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keycode   (keycode),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   always #250 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid) begin
            kv_cnt++;
            kc_log.push_back(keycode);
         end
         if (frame_err) fe_cnt++;
         if (key_valid && frame_err) both_cnt++;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par, input logic stop);
      return {stop, par, b, 1'b0};
   endfunction

   function automatic logic odd_par(input logic [7:0] b);
      return ~(^b);
   endfunction

   // Sends bits[0..n-1]; optional short low glitches during the high phase of data bits.
   task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         if (glitch && i >= 1 && i <= 8) begin
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(GLITCH_LEN);
            ps2_clk = 1'b1;
            wait_cyc(QTR - 10 - GLITCH_LEN);
         end else begin
            wait_cyc(QTR);
         end
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
         wait_cyc(QTR);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b, input bit glitch);
      send_bits(mk_frame(b, odd_par(b), 1'b1), 11, glitch);
      wait_cyc(40);
      exp_kc = {exp_kc[7:0], b};
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(20);
      exp_kc = 16'h0000;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      exp_kc   = 16'h0000;
      wait_cyc(5);
      tests_run++;
      if (keycode !== 16'h0000 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_in_rst: keycode=%h kv=%b fe=%b required 0000/0/0", keycode, key_valid, frame_err);
      end
      rst = 1'b0;
      wait_cyc(30);
      tests_run++;
      if (keycode !== 16'h0000 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: keycode=%h kv=%b fe=%b required 0000/0/0", keycode, key_valid, frame_err);
      end
   endtask

   task automatic test_single();
      int kv0 = kv_cnt;
      int fe0 = fe_cnt;
      send_good(8'h5A, 1'b0);
      tests_run++;
      if (kv_cnt - kv0 != 1) begin
         tests_failed++;
         $display("FAIL single_kv_count: got %0d required 1", kv_cnt - kv0);
      end
      tests_run++;
      if (keycode !== 16'h005A) begin
         tests_failed++;
         $display("FAIL single_keycode: got %h required 005a", keycode);
      end
      tests_run++;
      if (fe_cnt != fe0) begin
         tests_failed++;
         $display("FAIL single_no_err: got %0d errors required 0", fe_cnt - fe0);
      end
   endtask

   task automatic test_sequence();
      logic [15:0] exp_seq[3];
      int          lg0;
      exp_seq[0] = 16'h005A;
      exp_seq[1] = 16'h5AF0;
      exp_seq[2] = 16'hF05A;
      apply_reset();
      lg0 = kc_log.size();
      send_good(8'h5A, 1'b0);
      send_good(8'hF0, 1'b0);
      send_good(8'h5A, 1'b0);
      tests_run++;
      if (kc_log.size() - lg0 != 3) begin
         tests_failed++;
         $display("FAIL seq_kv_count: got %0d required 3", kc_log.size() - lg0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (kc_log[lg0 + i] !== exp_seq[i]) begin
               tests_failed++;
               $display("FAIL seq_keycode_%0d: got %h required %h", i, kc_log[lg0 + i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_parity_err();
      int kv0 = kv_cnt;
      int fe0 = fe_cnt;
      send_bits(mk_frame(8'h2D, 1'b0, 1'b1), 11, 1'b0);
      wait_cyc(40);
      tests_run++;
      if (fe_cnt - fe0 != 1 || kv_cnt != kv0) begin
         tests_failed++;
         $display("FAIL parity_err_pulses: fe=%0d kv=%0d required fe=1 kv=0", fe_cnt - fe0, kv_cnt - kv0);
      end
      tests_run++;
      if (keycode !== exp_kc) begin
         tests_failed++;
         $display("FAIL parity_err_keycode: got %h required %h", keycode, exp_kc);
      end
      send_good(8'h2D, 1'b0);
      tests_run++;
      if (keycode !== 16'h5A2D || kv_cnt - kv0 != 1) begin
         tests_failed++;
         $display("FAIL parity_recover: got %h kv=%0d required 5a2d kv=1", keycode, kv_cnt - kv0);
      end
   endtask

   task automatic test_stop_err();
      int kv0 = kv_cnt;
      int fe0 = fe_cnt;
      send_bits(mk_frame(8'h5A, 1'b1, 1'b0), 11, 1'b0);
      wait_cyc(40);
      tests_run++;
      if (fe_cnt - fe0 != 1 || kv_cnt != kv0) begin
         tests_failed++;
         $display("FAIL stop_err_pulses: fe=%0d kv=%0d required fe=1 kv=0", fe_cnt - fe0, kv_cnt - kv0);
      end
      tests_run++;
      if (keycode !== 16'h5A2D) begin
         tests_failed++;
         $display("FAIL stop_err_keycode: got %h required 5a2d", keycode);
      end
   endtask

   task automatic test_timeout();
      logic [10:0] bits;
      int          n;
      bit          seen;
      int          fe0 = fe_cnt;
      bits = mk_frame(8'h15, 1'b0, 1'b1);
      send_bits(bits, 5, 1'b0);
      ps2_data = bits[5];
      wait_cyc(QTR);
      ps2_clk = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < TO_LATENCY + 50) begin
         @(negedge clk);
         n++;
         if (n == HALF) ps2_clk = 1'b1;
         if (frame_err) seen = 1'b1;
      end
      ps2_data = 1'b1;
      tests_run++;
      if (!seen || n != TO_LATENCY) begin
         tests_failed++;
         $display("FAIL timeout_latency: seen=%0b at %0d cycles required %0d", seen, n, TO_LATENCY);
      end
      wait_cyc(300);
      tests_run++;
      if (fe_cnt - fe0 != 1 || keycode !== 16'h5A2D) begin
         tests_failed++;
         $display("FAIL timeout_once: fe=%0d keycode=%h required 1 and 5a2d", fe_cnt - fe0, keycode);
      end
      send_good(8'h2D, 1'b0);
      tests_run++;
      if (keycode !== 16'h2D2D) begin
         tests_failed++;
         $display("FAIL timeout_recover: got %h required 2d2d", keycode);
      end
   endtask

   task automatic test_glitch_and_reset();
      int kv0 = kv_cnt;
      int fe0 = fe_cnt;
      send_good(8'h5A, 1'b1);
      tests_run++;
      if (keycode !== 16'h2D5A || kv_cnt - kv0 != 1 || fe_cnt != fe0) begin
         tests_failed++;
         $display("FAIL glitch_decode: got %h kv=%0d fe=%0d required 2d5a kv=1 fe=0", keycode, kv_cnt - kv0, fe_cnt - fe0);
      end
      send_bits(mk_frame(8'h2D, 1'b1, 1'b1), 4, 1'b0);
      rst = 1'b1;
      wait_cyc(3);
      tests_run++;
      if (keycode !== 16'h0000 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL midframe_reset: keycode=%h kv=%b fe=%b required 0000/0/0", keycode, key_valid, frame_err);
      end
      rst = 1'b0;
      exp_kc = 16'h0000;
      fe0 = fe_cnt;
      wait_cyc(TO_CYC + 100);
      tests_run++;
      if (fe_cnt != fe0) begin
         tests_failed++;
         $display("FAIL reset_discard: got %0d errors required 0", fe_cnt - fe0);
      end
      send_good(8'h5A, 1'b0);
      tests_run++;
      if (keycode !== 16'h005A) begin
         tests_failed++;
         $display("FAIL reset_next_frame: got %h required 005a", keycode);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_parity_err();
      test_stop_err();
      test_timeout();
      test_glitch_and_reset();
      tests_run++;
      if (both_cnt != 0) begin
         tests_failed++;
         $display("FAIL kv_fe_overlap: got %0d overlapping cycles required 0", both_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
